llsc_reservation_monitor: RTL and testbench

- Sits between the round-robin L1 arbiter and the shared L2 in the multicore system.
- Keeps one load-linked reservation per core and resolves store-conditional (SC) success centrally.
- Kills a core's reservation when any other core's store or successful SC hits the same line.
- Failed SCs are answered locally and never reach L2. All other requests pass to L2 with one outstanding transaction at a time.

---
 rtl/mc_common_pkg.sv | 39 +++
 rtl/llsc_resv_table.sv | 62 ++++++
 rtl/llsc_reservation_monitor.sv | 156 +++++++++++++++
 tb/tb_llsc_reservation_monitor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_common_pkg.sv
// rtl/mc_common_pkg.sv - shared memory request/response types and LL/SC definitions
package mc_common_pkg;

   localparam int NCORES             = 4;
   localparam int MEM_ADDR_W         = 32;
   localparam int MEM_DATA_W         = 32;
   localparam int LINE_BYTES_DEFAULT = 16;
   localparam int TAG_W_DEFAULT      = MEM_ADDR_W - $clog2(LINE_BYTES_DEFAULT);

   // Request as seen on both the arbiter side and the L2 side
   typedef struct packed {
      logic                  valid;
      logic [MEM_ADDR_W-1:0] addr;
      logic                  we;
      logic [MEM_DATA_W-1:0] wdata;
      logic                  ll;
      logic                  sc;
   } mem_req_t;

   typedef struct packed {
      logic                  valid;
      logic [MEM_DATA_W-1:0] rdata;
      logic                  sc_success;
   } mem_resp_t;

   // One reservation slot at the default line granularity
   typedef struct packed {
      logic                     v;
      logic [TAG_W_DEFAULT-1:0] tag;
   } resv_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2,
      FAIL = 2'd3
   } llsc_state_e;

endpackage

// File: rtl/llsc_resv_table.sv
// rtl/llsc_resv_table.sv - per-core load-linked reservation storage with set/kill/clear/lookup
module llsc_resv_table #(
   parameter int NCORES = 4,
   parameter int TAG_W  = 28
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      set_i,
   input  logic [$clog2(NCORES)-1:0] set_core_i,
   input  logic [TAG_W-1:0]          set_tag_i,
   input  logic                      kill_i,
   input  logic [TAG_W-1:0]          kill_tag_i,
   input  logic                      clr_i,
   input  logic [$clog2(NCORES)-1:0] clr_core_i,
   input  logic [$clog2(NCORES)-1:0] lookup_core_i,
   output logic                      lookup_v_o,
   output logic [TAG_W-1:0]          lookup_tag_o,
   output logic [NCORES-1:0]         valid_o
);

   logic [NCORES-1:0] v_q, v_d;
   logic [TAG_W-1:0]  tag_q [NCORES];
   logic [TAG_W-1:0]  tag_d [NCORES];

   // Apply kill, then own-clear, then set; the controller issues at most one per cycle
   always_comb begin
      v_d   = v_q;
      tag_d = tag_q;
      if (kill_i) begin
         for (int i = 0; i < NCORES; i++) begin
            if (v_q[i] && (tag_q[i] == kill_tag_i)) begin
               v_d[i] = 1'b0;
            end
         end
      end
      if (clr_i) begin
         v_d[clr_core_i] = 1'b0;
      end
      if (set_i) begin
         v_d[set_core_i]   = 1'b1;
         tag_d[set_core_i] = set_tag_i;
      end
   end

   // Reservation registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int i = 0; i < NCORES; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         v_q   <= v_d;
         tag_q <= tag_d;
      end
   end

   assign lookup_v_o   = v_q[lookup_core_i];
   assign lookup_tag_o = tag_q[lookup_core_i];
   assign valid_o      = v_q;

endmodule

// File: rtl/llsc_reservation_monitor.sv
// rtl/llsc_reservation_monitor.sv - central LL/SC resolution between the L1 arbiter and L2
module llsc_reservation_monitor
   import mc_common_pkg::*;
#(
   parameter int NCORES     = mc_common_pkg::NCORES,
   parameter int LINE_BYTES = LINE_BYTES_DEFAULT,
   parameter int ADDR_W     = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  mem_req_t                  up_req,
   input  logic [$clog2(NCORES)-1:0] up_core,
   output mem_resp_t                 up_resp,
   output mem_req_t                  down_req,
   input  mem_resp_t                 down_resp,
   output logic [NCORES-1:0]         resv_valid,
   output logic [31:0]               sc_pass_cnt,
   output logic [31:0]               sc_fail_cnt
);

   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int TAG_W = ADDR_W - OFF_W;

   llsc_state_e     state_q, state_d;
   mem_req_t        down_q, down_d;
   logic            sc_succ_q, sc_succ_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [31:0]     pass_q, pass_d;
   logic [31:0]     fail_q, fail_d;

   logic             set_en, kill_en, clr_en;
   logic             lk_v;
   logic [TAG_W-1:0] lk_tag;
   logic [TAG_W-1:0] up_tag;
   logic             unused_resp_bits;

   assign up_tag           = up_req.addr[ADDR_W-1:OFF_W];
   assign unused_resp_bits = down_resp.sc_success;

   llsc_resv_table #(
      .NCORES (NCORES),
      .TAG_W  (TAG_W)
   ) u_resv_table (
      .clk           (clk),
      .rst_n         (rst_n),
      .set_i         (set_en),
      .set_core_i    (up_core),
      .set_tag_i     (up_tag),
      .kill_i        (kill_en),
      .kill_tag_i    (up_tag),
      .clr_i         (clr_en),
      .clr_core_i    (up_core),
      .lookup_core_i (up_core),
      .lookup_v_o    (lk_v),
      .lookup_tag_o  (lk_tag),
      .valid_o       (resv_valid)
   );

   // Classify at acceptance, drive reservation updates, track the single L2 transaction
   always_comb begin
      state_d   = state_q;
      down_d    = down_q;
      sc_succ_d = sc_succ_q;
      rdata_d   = rdata_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      set_en    = 1'b0;
      kill_en   = 1'b0;
      clr_en    = 1'b0;
      up_resp   = '0;

      case (state_q)
         IDLE: begin
            if (up_req.valid) begin
               if (up_req.sc) begin
                  // An SC carrying ll as well is still resolved as an SC
                  if (lk_v && (lk_tag == up_tag)) begin
                     kill_en      = 1'b1;
                     down_d       = up_req;
                     down_d.valid = 1'b1;
                     down_d.we    = 1'b1;
                     down_d.ll    = 1'b0;
                     down_d.sc    = 1'b0;
                     sc_succ_d    = 1'b1;
                     state_d      = WAIT;
                  end else begin
                     clr_en    = 1'b1;
                     sc_succ_d = 1'b0;
                     state_d   = FAIL;
                  end
               end else begin
                  if (up_req.ll) begin
                     set_en = 1'b1;
                  end else if (up_req.we) begin
                     kill_en = 1'b1;
                  end
                  down_d       = up_req;
                  down_d.valid = 1'b1;
                  sc_succ_d    = 1'b0;
                  state_d      = WAIT;
               end
            end
         end
         WAIT: begin
            if (down_resp.valid) begin
               rdata_d = down_resp.rdata;
               down_d  = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            up_resp.valid      = 1'b1;
            up_resp.rdata      = rdata_q;
            up_resp.sc_success = sc_succ_q;
            if (sc_succ_q && (pass_q != 32'hFFFF_FFFF)) begin
               pass_d = pass_q + 32'd1;
            end
            state_d = IDLE;
         end
         FAIL: begin
            up_resp.valid = 1'b1;
            if (fail_q != 32'hFFFF_FFFF) begin
               fail_d = fail_q + 32'd1;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, L2 request holding register, response data and SC counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         down_q    <= '0;
         sc_succ_q <= 1'b0;
         rdata_q   <= '0;
         pass_q    <= '0;
         fail_q    <= '0;
      end else begin
         state_q   <= state_d;
         down_q    <= down_d;
         sc_succ_q <= sc_succ_d;
         rdata_q   <= rdata_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
      end
   end

   assign down_req    = down_q;
   assign sc_pass_cnt = pass_q;
   assign sc_fail_cnt = fail_q;

endmodule

// File: tb/tb_llsc_reservation_monitor.sv
// tb/tb_llsc_reservation_monitor.sv - self-checking bench for llsc_reservation_monitor
module tb_llsc_reservation_monitor;
   import mc_common_pkg::*;

   localparam int NC = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   mem_req_t    up_req;
   logic [1:0]  up_core;
   mem_resp_t   up_resp;
   mem_req_t    down_req;
   mem_resp_t   down_resp;
   logic [NC-1:0] resv_valid;
   logic [31:0] sc_pass_cnt;
   logic [31:0] sc_fail_cnt;

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit          m_v   [NC];
   logic [27:0] m_tag [NC];
   int          m_pass;
   int          m_fail;
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] l2_mem  [logic [31:0]];

   // observations of one transaction
   int        obs_l2_cnt;
   mem_req_t  obs_l2_req;
   bit        obs_stable;
   mem_resp_t obs_resp;
   int        obs_lat;
   bit        obs_timeout;

   always #5 clk = ~clk;

   llsc_reservation_monitor #(
      .NCORES     (NC),
      .LINE_BYTES (16),
      .ADDR_W     (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .up_req      (up_req),
      .up_core     (up_core),
      .up_resp     (up_resp),
      .down_req    (down_req),
      .down_resp   (down_resp),
      .resv_valid  (resv_valid),
      .sc_pass_cnt (sc_pass_cnt),
      .sc_fail_cnt (sc_fail_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {16'hD00D, a[15:0]};
   endfunction

   function automatic logic [NC-1:0] model_resv();
      logic [NC-1:0] r;
      for (int i = 0; i < NC; i++) r[i] = m_v[i];
      return r;
   endfunction

   function automatic void model_kill(input logic [27:0] t);
      for (int i = 0; i < NC; i++) begin
         if (m_v[i] && m_tag[i] == t) m_v[i] = 1'b0;
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NC; i++) begin
         m_v[i]   = 1'b0;
         m_tag[i] = '0;
      end
      m_pass = 0;
      m_fail = 0;
   endfunction

   // Drive one request and play the L2 side until the up_resp pulse or a cycle budget expires
   task automatic run_req(input int core, input logic [31:0] addr, input bit we,
                          input logic [31:0] wdata, input bit ll, input bit sc, input int delay);
      int dly;
      @(negedge clk);
      up_core      = core[1:0];
      up_req.valid = 1'b1;
      up_req.addr  = addr;
      up_req.we    = we;
      up_req.wdata = wdata;
      up_req.ll    = ll;
      up_req.sc    = sc;
      obs_l2_cnt   = 0;
      obs_l2_req   = '0;
      obs_stable   = 1'b1;
      obs_resp     = '0;
      obs_lat      = 0;
      obs_timeout  = 1'b1;
      dly          = delay;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         down_resp = '0;
         if (up_resp.valid) begin
            obs_resp    = up_resp;
            obs_lat     = k;
            obs_timeout = 1'b0;
            break;
         end
         if (down_req.valid) begin
            if (dly < 0) begin
               obs_l2_cnt++;
            end else begin
               if (obs_l2_cnt == 0) begin
                  obs_l2_cnt = 1;
                  obs_l2_req = down_req;
               end else if (down_req !== obs_l2_req) begin
                  obs_stable = 1'b0;
               end
               if (dly == 0) begin
                  down_resp.valid = 1'b1;
                  if (down_req.we) begin
                     down_resp.rdata = 32'h0;
                     l2_mem[down_req.addr] = down_req.wdata;
                  end else begin
                     down_resp.rdata = l2_mem.exists(down_req.addr) ? l2_mem[down_req.addr]
                                                                    : init_word(down_req.addr);
                  end
                  dly = -1;
               end else begin
                  dly--;
               end
            end
         end
      end
      up_req    = '0;
      down_resp = '0;
   endtask

   // Predict a transaction from the reservation rules, run it, then compare everything
   task automatic txn(input int core, input logic [31:0] addr, input bit we,
                      input logic [31:0] wdata, input bit ll, input bit sc, input int delay);
      logic [27:0] t;
      bit          ok;
      bit          fwd;
      bit          exp_we;
      logic [31:0] exp_rdata;
      t         = addr[31:4];
      ok        = sc && m_v[core] && (m_tag[core] == t);
      fwd       = !sc || ok;
      exp_we    = sc ? 1'b1 : we;
      exp_rdata = (!fwd || exp_we) ? 32'h0
                : (ref_mem.exists(addr) ? ref_mem[addr] : init_word(addr));

      run_req(core, addr, we, wdata, ll, sc, delay);

      if (sc) begin
         if (ok) begin
            model_kill(t);
            ref_mem[addr] = wdata;
            if (m_pass < 32'hFFFF_FFFF) m_pass++;
         end else begin
            m_v[core] = 1'b0;
            m_fail++;
         end
      end else if (ll) begin
         m_v[core]   = 1'b1;
         m_tag[core] = t;
      end else if (we) begin
         model_kill(t);
         ref_mem[addr] = wdata;
      end

      check("resp_timeout", obs_timeout, 0);
      check("l2_count", obs_l2_cnt, fwd ? 1 : 0);
      if (fwd) begin
         check("l2_addr", obs_l2_req.addr, addr);
         check("l2_we", obs_l2_req.we, exp_we);
         if (exp_we) check("l2_wdata", obs_l2_req.wdata, wdata);
         check("l2_ll", obs_l2_req.ll, sc ? 1'b0 : ll);
         check("l2_sc", obs_l2_req.sc, 0);
         check("l2_stable", obs_stable, 1);
         check("fwd_latency", obs_lat, delay + 2);
      end else begin
         check("fail_latency", obs_lat, 1);
      end
      check("rdata", obs_resp.rdata, exp_rdata);
      check("sc_success", obs_resp.sc_success, ok);
      @(negedge clk);
      check("resv_valid", resv_valid, model_resv());
      check("sc_pass_cnt", sc_pass_cnt, m_pass);
      check("sc_fail_cnt", sc_fail_cnt, m_fail);
      check("idle_no_resp", up_resp.valid, 0);
   endtask

   initial begin
      int          op;
      int          hold;
      logic [31:0] a;

      rst_n     = 1'b0;
      up_req    = '0;
      up_core   = '0;
      down_resp = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_down_req", down_req, 0);
      check("rst_up_resp", up_resp, 0);
      check("rst_resv", resv_valid, 0);
      check("rst_pass", sc_pass_cnt, 0);
      check("rst_fail", sc_fail_cnt, 0);
      rst_n = 1'b1;

      // LL then SC by the same core succeeds
      txn(0, 32'h100, 0, 32'h0, 1, 0, 1);
      check("ll_sets_resv", resv_valid[0], 1);
      txn(0, 32'h100, 1, 32'hA5, 0, 1, 0);
      check("sc_clears_own", resv_valid[0], 0);

      // another core's store to the same line kills the reservation
      txn(0, 32'h100, 0, 32'h0, 1, 0, 0);
      txn(1, 32'h10C, 1, 32'h1234, 0, 0, 2);
      txn(0, 32'h100, 1, 32'h5A, 0, 1, 0);

      // store to a neighbouring line leaves it intact
      txn(0, 32'h100, 0, 32'h0, 1, 0, 0);
      txn(1, 32'h110, 1, 32'h777, 0, 0, 1);
      txn(0, 32'h100, 1, 32'h66, 0, 1, 3);

      // SC with no prior LL
      txn(2, 32'h200, 1, 32'h99, 0, 1, 0);

      // two reservations on one line, the first successful SC kills both
      txn(0, 32'h40, 0, 32'h0, 1, 0, 0);
      txn(1, 32'h40, 0, 32'h0, 1, 0, 0);
      txn(1, 32'h40, 1, 32'h11, 0, 1, 1);
      check("both_killed", resv_valid, 0);
      txn(0, 32'h40, 1, 32'h22, 0, 1, 0);

      // SC with ll also set behaves as SC
      txn(3, 32'h130, 0, 32'h0, 1, 0, 0);
      txn(3, 32'h130, 1, 32'h33, 1, 1, 0);

      // randomized traffic over four lines
      for (int n = 0; n < 150; n++) begin
         op = $urandom_range(0, 5);
         a  = 32'h100 + ($urandom_range(0, 15) << 2);
         case (op)
            0:       txn($urandom_range(0, 3), a, 0, 32'h0, 0, 0, $urandom_range(0, 3));
            1:       txn($urandom_range(0, 3), a, 1, $urandom, 0, 0, $urandom_range(0, 3));
            2, 3:    txn($urandom_range(0, 3), a, 0, 32'h0, 1, 0, $urandom_range(0, 3));
            4:       txn($urandom_range(0, 3), a, 1, $urandom, 0, 1, $urandom_range(0, 3));
            default: txn($urandom_range(0, 3), a, $urandom_range(0, 1), $urandom, 1, 1, $urandom_range(0, 3));
         endcase
      end

      // reset while an L2 response is still pending
      txn(1, 32'h120, 0, 32'h0, 1, 0, 0);
      @(negedge clk);
      up_core      = 2'd3;
      up_req.valid = 1'b1;
      up_req.addr  = 32'h124;
      up_req.we    = 1'b0;
      hold         = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (down_req.valid) begin
            hold = 1;
            break;
         end
      end
      check("wait_reached", hold, 1);
      rst_n = 1'b0;
      @(negedge clk);
      up_req = '0;
      rst_n  = 1'b1;
      model_reset();
      check("mid_rst_resv", resv_valid, 0);
      check("mid_rst_down_valid", down_req.valid, 0);
      check("mid_rst_resp", up_resp.valid, 0);
      check("mid_rst_pass", sc_pass_cnt, 0);
      @(negedge clk);
      check("post_rst_resp", up_resp.valid, 0);
      check("post_rst_down_valid", down_req.valid, 0);
      txn(2, 32'h128, 0, 32'h0, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
